// File: rtl/march_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : march_bist_ctrl
//  Purpose  : March C- memory BIST controller. Sequences the six March C-
//             elements over addresses 0..LAST_ADDR, drives the memory command
//             bus, compares read data (2-cycle read latency) against the
//             expected background and captures the first mismatch.
//  Ports    : clk, rst         - clock (rising edge), async active-high reset
//             start            - request one test (ignored while busy)
//             busy, done       - test in progress / finished (done sticky)
//             fail, fail_*     - sticky mismatch flag and first-mismatch info
//             write_read       - memory command, 1 = write, 0 = read
//             address, wdata   - memory address and write data
//             rdata            - memory read data (valid 2 cycles after read)
//  Revision : 1.0 - initial release
// ============================================================================
module march_bist_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int LAST_ADDR  = 2**ADDR_WIDTH-1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  fail,
  output logic [2:0]            fail_elem,
  output logic [ADDR_WIDTH-1:0] fail_addr,
  output logic [DATA_WIDTH-1:0] fail_exp,
  output logic [DATA_WIDTH-1:0] fail_data,
  output logic                  write_read,
  output logic [ADDR_WIDTH-1:0] address,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] rdata
);

  localparam logic [2:0] c_st_idle  = 3'd0;
  localparam logic [2:0] c_st_setup = 3'd1;
  localparam logic [2:0] c_st_run   = 3'd2;
  localparam logic [2:0] c_st_drain = 3'd3;
  localparam logic [2:0] c_st_done  = 3'd4;

  localparam logic [2:0] c_last_elem = 3'd5;
  localparam logic [ADDR_WIDTH-1:0] c_last_addr = ADDR_WIDTH'(LAST_ADDR);

  // Sequencer state
  logic [2:0]            r_state;
  logic [2:0]            r_elem;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_phase;   // two-op elements: 0 = read slot, 1 = write slot
  logic                  r_drain;   // DRAIN cycle counter (2 cycles)

  logic [2:0]            w_state_nxt;
  logic [2:0]            w_elem_nxt;
  logic [ADDR_WIDTH-1:0] w_addr_nxt;
  logic                  w_phase_nxt;
  logic                  w_drain_nxt;

  // Per-element decode
  logic                  w_two_op;
  logic                  w_down;
  logic                  w_nxt_down;
  logic                  w_at_last;
  logic                  w_is_write;
  logic                  w_rd_issue;
  logic                  w_accept;
  logic [DATA_WIDTH-1:0] w_bg_wr;
  logic [DATA_WIDTH-1:0] w_exp_rd;

  // Read-compare pipeline, two stages to match the memory read latency
  logic                  r_p1_vld, r_p2_vld;
  logic [DATA_WIDTH-1:0] r_p1_exp, r_p2_exp;
  logic [ADDR_WIDTH-1:0] r_p1_addr, r_p2_addr;
  logic [2:0]            r_p1_elem, r_p2_elem;
  logic                  w_mismatch;

  // M1..M4 are read+write elements; M0 is write-only and M5 is read-only.
  assign w_two_op   = (r_elem >= 3'd1) && (r_elem <= 3'd4);
  assign w_down     = (r_elem == 3'd3) || (r_elem == 3'd4);
  // Direction of the element that follows the current one.
  assign w_nxt_down = (r_elem == 3'd2) || (r_elem == 3'd3);
  assign w_at_last  = w_down ? (r_addr == '0) : (r_addr == c_last_addr);
  // Write background: ones for M1 (w1) and M3 (w1), zeros otherwise.
  assign w_bg_wr    = {DATA_WIDTH{(r_elem == 3'd1) || (r_elem == 3'd3)}};
  // Read expectation: ones for M2 (r1) and M4 (r1), zeros otherwise.
  assign w_exp_rd   = {DATA_WIDTH{(r_elem == 3'd2) || (r_elem == 3'd4)}};
  assign w_is_write = w_two_op ? r_phase : (r_elem == 3'd0);
  assign w_rd_issue = (r_state == c_st_run) && !w_is_write;
  assign w_accept   = start && ((r_state == c_st_idle) || (r_state == c_st_done));
  assign w_mismatch = r_p2_vld && (rdata != r_p2_exp);

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= c_st_idle;
      r_elem  <= 3'd0;
      r_addr  <= '0;
      r_phase <= 1'b0;
      r_drain <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_elem  <= w_elem_nxt;
      r_addr  <= w_addr_nxt;
      r_phase <= w_phase_nxt;
      r_drain <= w_drain_nxt;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    w_elem_nxt  = r_elem;
    w_addr_nxt  = r_addr;
    w_phase_nxt = r_phase;
    w_drain_nxt = r_drain;
    case (r_state)
      c_st_idle, c_st_done: begin
        if (start) begin
          w_state_nxt = c_st_setup;
          w_elem_nxt  = 3'd0;
          w_addr_nxt  = '0;
          w_phase_nxt = 1'b0;
        end
      end
      c_st_setup: begin
        // Address was already loaded with the element's first address.
        w_state_nxt = c_st_run;
        w_phase_nxt = 1'b0;
      end
      c_st_run: begin
        if (w_two_op && !r_phase) begin
          w_phase_nxt = 1'b1;
        end else begin
          w_phase_nxt = 1'b0;
          if (w_at_last) begin
            if (r_elem == c_last_elem) begin
              w_state_nxt = c_st_drain;
              w_drain_nxt = 1'b0;
            end else begin
              w_state_nxt = c_st_setup;
              w_elem_nxt  = r_elem + 3'd1;
              w_addr_nxt  = w_nxt_down ? c_last_addr : '0;
            end
          end else begin
            w_addr_nxt = w_down ? (r_addr - 1'b1) : (r_addr + 1'b1);
          end
        end
      end
      c_st_drain: begin
        if (r_drain) w_state_nxt = c_st_done;
        else         w_drain_nxt = 1'b1;
      end
      default: w_state_nxt = c_st_idle;
    endcase
  end

  // --------------------------------------------------------------------------
  // Output logic
  // --------------------------------------------------------------------------
  always_comb begin
    busy       = 1'b0;
    done       = 1'b0;
    write_read = 1'b0;
    address    = '0;
    wdata      = '0;
    case (r_state)
      c_st_setup: begin
        // Write data is presented here, a cycle ahead of the first write,
        // because the memory samples write data one cycle late.
        busy    = 1'b1;
        address = r_addr;
        wdata   = w_bg_wr;
      end
      c_st_run: begin
        busy       = 1'b1;
        address    = r_addr;
        wdata      = w_bg_wr;
        write_read = w_is_write;
      end
      c_st_drain: begin
        busy  = 1'b1;
        wdata = w_bg_wr;
      end
      c_st_done: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

  // --------------------------------------------------------------------------
  // Read-compare pipeline: carries expected word, address and element along
  // with the read until its data returns on rdata.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_p1_vld  <= 1'b0;
      r_p1_exp  <= '0;
      r_p1_addr <= '0;
      r_p1_elem <= 3'd0;
      r_p2_vld  <= 1'b0;
      r_p2_exp  <= '0;
      r_p2_addr <= '0;
      r_p2_elem <= 3'd0;
    end else begin
      r_p1_vld  <= w_rd_issue;
      r_p1_exp  <= w_exp_rd;
      r_p1_addr <= r_addr;
      r_p1_elem <= r_elem;
      r_p2_vld  <= r_p1_vld;
      r_p2_exp  <= r_p1_exp;
      r_p2_addr <= r_p1_addr;
      r_p2_elem <= r_p1_elem;
    end
  end

  // --------------------------------------------------------------------------
  // First-mismatch capture; cleared only by an accepted start or reset.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail      <= 1'b0;
      fail_elem <= 3'd0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_data <= '0;
    end else if (w_accept) begin
      fail      <= 1'b0;
      fail_elem <= 3'd0;
      fail_addr <= '0;
      fail_exp  <= '0;
      fail_data <= '0;
    end else if (w_mismatch && !fail) begin
      fail      <= 1'b1;
      fail_elem <= r_p2_elem;
      fail_addr <= r_p2_addr;
      fail_exp  <= r_p2_exp;
      fail_data <= rdata;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_march_bist_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_march_bist_ctrl
//  Purpose  : Self-checking bench for march_bist_ctrl with a behavioural
//             16x8 memory (2-cycle read latency, write data lagging one
//             cycle) and injectable stuck-at faults.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_march_bist_ctrl;

  logic       clk;
  logic       rst;
  logic       start;
  logic       busy, done, fail;
  logic [2:0] fail_elem;
  logic [3:0] fail_addr;
  logic [7:0] fail_exp, fail_data;
  logic       write_read;
  logic [3:0] address;
  logic [7:0] wdata;
  logic [7:0] rdata;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic       wr;
    logic [3:0] ad;
    logic [7:0] wd;
    bit         chk_ad;
    bit         chk_wd;
  } bus_t;

  typedef struct {
    bit         f;
    logic [2:0] el;
    logic [3:0] ad;
    logic [7:0] ex;
    logic [7:0] da;
  } res_t;

  bus_t bus_q[$];
  res_t res_q[$];

  march_bist_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .start(start),
    .busy(busy), .done(done), .fail(fail),
    .fail_elem(fail_elem), .fail_addr(fail_addr),
    .fail_exp(fail_exp), .fail_data(fail_data),
    .write_read(write_read), .address(address),
    .wdata(wdata), .rdata(rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory model with up to two stuck-at faults applied on read
  logic [7:0] mem [16];
  logic [7:0] wdata_q;
  logic [7:0] rd1;
  bit         f_en  [2];
  logic [3:0] f_addr[2];
  int         f_bit [2];
  logic       f_val [2];

  function automatic logic [7:0] mem_rd(input logic [3:0] a);
    logic [7:0] v;
    v = mem[a];
    for (int k = 0; k < 2; k++)
      if (f_en[k] && f_addr[k] == a) v[f_bit[k]] = f_val[k];
    return v;
  endfunction

  always @(posedge clk) begin
    wdata_q <= wdata;
    if (write_read === 1'b1) mem[address] <= wdata_q;
    rd1   <= mem_rd(address);
    rdata <= rd1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end

  task automatic clear_faults();
    for (int k = 0; k < 2; k++) begin
      f_en[k] = 0; f_addr[k] = 4'd0; f_bit[k] = 0; f_val[k] = 1'b0;
    end
  endtask

  // Expected bus activity of a full March C- run, cycle by cycle
  task automatic push_expected_bus();
    bus_q.delete();
    for (int e = 0; e < 6; e++) begin
      logic [7:0] bg;
      bit         down, two, chkwd;
      logic [3:0] a;
      bg    = (e == 1 || e == 3) ? 8'hFF : 8'h00;
      down  = (e == 3 || e == 4);
      two   = (e >= 1 && e <= 4);
      chkwd = (e != 5);
      bus_q.push_back('{1'b0, down ? 4'd15 : 4'd0, bg, 1'b1, chkwd});
      for (int i = 0; i < 16; i++) begin
        a = down ? 4'(15 - i) : 4'(i);
        if (two) begin
          bus_q.push_back('{1'b0, a, bg, 1'b1, 1'b1});
          bus_q.push_back('{1'b1, a, bg, 1'b1, 1'b1});
        end else begin
          bus_q.push_back('{(e == 0), a, bg, 1'b1, chkwd});
        end
      end
    end
    bus_q.push_back('{1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
    bus_q.push_back('{1'b0, 4'd0, 8'h00, 1'b0, 1'b0});
  endtask

  task automatic run_march(input string tag, input bit repulse, input int abort_at,
                           input bit e_fail, input logic [2:0] e_elem,
                           input logic [3:0] e_addr, input logic [7:0] e_exp,
                           input logic [7:0] e_data);
    int   n;
    bit   ok;
    bus_t b;
    res_t r;
    push_expected_bus();
    res_q.push_back('{e_fail, e_elem, e_addr, e_exp, e_data});
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    tests++;
    if (busy !== 1'b1 || done !== 1'b0 || fail !== 1'b0) begin
      fails++;
      $display("FAIL %s start_accept: busy=%b done=%b fail=%b, want 1 0 0", tag, busy, done, fail);
    end
    n = 0;
    while (busy === 1'b1 && n < 400) begin
      tests++;
      if (bus_q.size() == 0) begin
        fails++;
        $display("FAIL %s bus_extra[%0d]: busy still 1, want 0", tag, n);
      end else begin
        b  = bus_q.pop_front();
        ok = (write_read === b.wr) && (!b.chk_ad || address === b.ad) &&
             (!b.chk_wd || wdata === b.wd);
        if (!ok) begin
          fails++;
          $display("FAIL %s bus[%0d]: got wr=%b addr=%h wdata=%h, want wr=%b addr=%h wdata=%h",
                   tag, n, write_read, address, wdata, b.wr, b.ad, b.wd);
        end
      end
      n++;
      if (abort_at != 0 && n == abort_at) break;
      start = repulse && (n == 10 || n == 100);
      @(negedge clk);
    end
    start = 1'b0;
    if (abort_at != 0 && n == abort_at) return;
    r = res_q.pop_front();
    tests++;
    if (n !== 168) begin
      fails++;
      $display("FAIL %s busy_cycles: got %0d, want 168", tag, n);
    end
    tests++;
    if (done !== 1'b1 || write_read !== 1'b0) begin
      fails++;
      $display("FAIL %s done_state: done=%b wr=%b, want 1 0", tag, done, write_read);
    end
    tests++;
    if (fail !== r.f) begin
      fails++;
      $display("FAIL %s fail_flag: got %b, want %b", tag, fail, r.f);
    end
    if (r.f) begin
      tests++;
      if (fail_elem !== r.el || fail_addr !== r.ad || fail_exp !== r.ex || fail_data !== r.da) begin
        fails++;
        $display("FAIL %s capture: got elem=%0d addr=%h exp=%h data=%h, want elem=%0d addr=%h exp=%h data=%h",
                 tag, fail_elem, fail_addr, fail_exp, fail_data, r.el, r.ad, r.ex, r.da);
      end
    end
    repeat (3) @(negedge clk);
    tests++;
    if (done !== 1'b1 || busy !== 1'b0 || fail !== r.f) begin
      fails++;
      $display("FAIL %s sticky: done=%b busy=%b fail=%b, want 1 0 %b", tag, done, busy, fail, r.f);
    end
  endtask

  task automatic check_all_zero(input string tag);
    tests++;
    if ({busy, done, fail, fail_elem, fail_addr, fail_exp, fail_data,
         write_read, address, wdata} !== '0) begin
      fails++;
      $display("FAIL %s outputs: busy=%b done=%b fail=%b elem=%0d faddr=%h fexp=%h fdata=%h wr=%b addr=%h wdata=%h, want all 0",
               tag, busy, done, fail, fail_elem, fail_addr, fail_exp, fail_data,
               write_read, address, wdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0;
    clear_faults();
    for (int i = 0; i < 16; i++) mem[i] = 8'($urandom);
    #1;
    check_all_zero("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_all_zero("idle");
  endtask

  task automatic test_fault_free();
    clear_faults();
    run_march("fault_free", 0, 0, 0, 3'd0, 4'd0, 8'h00, 8'h00);
  endtask

  task automatic test_stuck_at0();
    clear_faults();
    f_en[0] = 1; f_addr[0] = 4'd5; f_bit[0] = 0; f_val[0] = 1'b0;
    run_march("sa0_a5b0", 0, 0, 1, 3'd2, 4'd5, 8'hFF, 8'hFE);
  endtask

  task automatic test_first_capture();
    clear_faults();
    f_en[0] = 1; f_addr[0] = 4'd0; f_bit[0] = 7; f_val[0] = 1'b1;
    f_en[1] = 1; f_addr[1] = 4'd5; f_bit[1] = 0; f_val[1] = 1'b0;
    run_march("sa1_a0b7", 0, 0, 1, 3'd1, 4'd0, 8'h00, 8'h80);
  endtask

  task automatic test_abort();
    clear_faults();
    f_en[0] = 1; f_addr[0] = 4'd0; f_bit[0] = 7; f_val[0] = 1'b1;
    run_march("abort", 0, 40, 1, 3'd1, 4'd0, 8'h00, 8'h80);
    tests++;
    if (fail !== 1'b1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL abort_pre: fail=%b busy=%b, want 1 1", fail, busy);
    end
    #2 rst = 1'b1;
    #1 check_all_zero("abort_reset");
    bus_q.delete();
    res_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL abort_idle: done=%b busy=%b, want 0 0", done, busy);
    end
    clear_faults();
    run_march("after_abort", 0, 0, 0, 3'd0, 4'd0, 8'h00, 8'h00);
  endtask

  task automatic test_back_to_back();
    clear_faults();
    run_march("restart_ignored", 1, 0, 0, 3'd0, 4'd0, 8'h00, 8'h00);
  endtask

  initial begin
    test_reset();
    test_fault_free();
    test_stuck_at0();
    test_first_capture();
    test_abort();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/march_bist_ctrl.md
MARCH_BIST_CTRL -- requirements
Module: march_bist_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, memory word width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 4, memory address width.
REQ-003 SHALL have parameter LAST_ADDR, default 2**ADDR_WIDTH-1, highest tested address; N = LAST_ADDR+1.
REQ-004 SHALL have port clk, input, 1, single clock; all flops on its rising edge.
REQ-005 SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-006 SHALL have port start, input, 1, request to run one test.
REQ-007 SHALL have port busy, output, 1, test in progress.
REQ-008 SHALL have port done, output, 1, test finished; sticky until next accepted start.
REQ-009 SHALL have port fail, output, 1, at least one mismatch seen; sticky.
REQ-010 SHALL have port fail_elem, output, 3, March element index of first mismatch.
REQ-011 SHALL have port fail_addr, output, ADDR_WIDTH, address of first mismatch.
REQ-012 SHALL have port fail_exp, output, DATA_WIDTH, expected word at first mismatch.
REQ-013 SHALL have port fail_data, output, DATA_WIDTH, read word at first mismatch.
REQ-014 SHALL have port write_read, output, 1, memory command: 1 = write, 0 = read.
REQ-015 SHALL have port address, output, ADDR_WIDTH, memory address.
REQ-016 SHALL have port wdata, output, DATA_WIDTH, memory write data.
REQ-017 SHALL have port rdata, input, DATA_WIDTH, memory read data.

Function
REQ-018 SHALL run March C-: M0 up-or-down(w0); M1 up(r0,w1); M2 up(r1,w0); M3 down(r0,w1); M4 down(r1,w0); M5 up-or-down(r0). M0 and M5 run ascending. Background 0 = all zeros, 1 = all ones.
REQ-019 SHALL implement FSM states IDLE, SETUP, RUN, DRAIN and DONE.
REQ-020 IDLE or DONE with start=1 at an edge SHALL go to SETUP. Accepting start clears done, fail and fail_* and sets busy.
REQ-021 start while busy SHALL be ignored.
REQ-022 SETUP SHALL last 1 cycle per element:
- wdata is driven with that element's write background.
- write_read=0; address is the element's first address.
- no compare is scheduled.
REQ-023 wdata SHALL stay constant for the whole element. Memory write data lags by one cycle, so data is presented at least one cycle before any write command.
REQ-024 RUN, two-op elements: per address, one read cycle (write_read=0) then one write cycle (write_read=1) at the same address.
REQ-025 RUN, one-op elements: one cycle per address.
REQ-026 Address SHALL step by 1 up to LAST_ADDR, or down to 0. The element ends after its last address, with no wrap.
REQ-027 After M4 SHALL enter SETUP for M5. After M5 SHALL enter DRAIN for 2 cycles (write_read=0, no compare), then DONE.
REQ-028 In DONE: busy=0, done=1, write_read=0.
REQ-029 Read latency is 2: for each RUN read, the expected word and its address SHALL be delayed 2 cycles with a valid bit.
REQ-030 When that valid bit is set, rdata SHALL be compared with the delayed expected word.
REQ-031 On the first mismatch SHALL capture fail_elem, fail_addr, fail_exp and fail_data, and set fail. Later mismatches SHALL NOT overwrite the capture.
REQ-032 Compares still in the pipeline at the end of M5 SHALL be completed in DRAIN, before done rises.
REQ-033 Total busy duration SHALL be exactly 10N+8 cycles: 10N operations, 6 SETUP cycles, 2 DRAIN cycles.
REQ-034 In IDLE: write_read=0, address=0, wdata=0.

Reset
REQ-035 rst=1 SHALL asynchronously force:
- state to IDLE;
- busy, done and fail to 0;
- fail_elem, fail_addr, fail_exp and fail_data to 0;
- write_read, address and wdata to 0;
- the compare pipeline valid bits to 0.
REQ-036 Reset during RUN SHALL abort the test with no done. Memory contents are then undefined, and a new start runs the full test.

Verification
REQ-037 Fault-free memory, DATA_WIDTH=8, ADDR_WIDTH=4, start pulse -> busy high 168 cycles, then done=1, fail=0.
REQ-038 Bit 0 of address 5 stuck-at-0 -> fail=1, fail_elem=2, fail_addr=5, fail_exp=8'hFF, fail_data=8'hFE, done after 168 cycles.
REQ-039 Bit 7 of address 0 stuck-at-1 -> fail_elem=1, fail_addr=0, fail_exp=8'h00, fail_data=8'h80. A second fault in a later element does not change the capture.
REQ-040 rst asserted 40 cycles into a run -> all outputs 0 immediately. A new start on a fault-free memory gives done after 168 cycles, fail=0.
REQ-041 start re-pulsed at cycles 10 and 100 of a run -> ignored; done still at cycle 168.
REQ-042 Bus check, first cycles after start -> SETUP (write_read=0, wdata=0), then 16 writes at addresses 0..15, then SETUP with wdata=8'hFF, then M1 alternating r/w at address 0.
